// File: rtl/serial_pkg.sv
// Shared constants and types for the FF01/FF02 serial link port.
package serial_pkg;

  localparam int unsigned SC_START_BIT   = 7;
  localparam int unsigned SC_CLKSEL_BIT  = 0;
  localparam logic [7:0]  SC_UNUSED_MASK = 8'h7E;
  localparam int unsigned SER_BITS       = 8;
  localparam int unsigned CNT_W          = $clog2(SER_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SER_BITS - 1);

  typedef enum logic {
    CLK_EXT = 1'b0,
    CLK_INT = 1'b1
  } clk_sel_e;

endpackage

// File: rtl/serial_edge_sync.sv
// Synchronizes the asynchronous SCK pin and emits one-clk rise/fall pulses.
module serial_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/serial_link.sv
// Serial link port: SB shift register, SC control, shift-clock generation and
// the transfer-complete interrupt.
module serial_link
  import serial_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  inout  tri   [7:0] d,
  input  logic ff01wr,
  input  logic ff01rd,
  input  logic ff02wr,
  input  logic ff02rd,
  input  logic tick_8192,
  input  logic sclk_in,
  input  logic sin,
  output logic ser_out,
  output logic sclk_out,
  output logic sclk_oe,
  output logic int_serial
);

  logic [SER_BITS-1:0] sb;
  logic                sc_start;
  clk_sel_e            sc_clk;
  logic [CNT_W-1:0]    cnt;
  logic                int_mode;
  logic                ext_rise;
  logic                ext_fall;
  logic                rise;
  logic                fall;
  logic [7:0]          sc_val;
  logic [7:0]          rd_data;

  serial_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk  (clk),
    .reset(reset),
    .din  (sclk_in),
    .rise (ext_rise),
    .fall (ext_fall)
  );

  assign int_mode = (sc_clk == CLK_INT);
  assign sclk_oe  = int_mode;

  // Internal edges are named by the sclk_out transition the tick is about to cause.
  always_comb begin
    rise = 1'b0;
    fall = 1'b0;
    if (sc_start) begin
      if (int_mode) begin
        rise = tick_8192 & ~sclk_out;
        fall = tick_8192 & sclk_out;
      end else begin
        rise = ext_rise;
        fall = ext_fall;
      end
    end
  end

  always_comb begin
    sc_val                = SC_UNUSED_MASK;
    sc_val[SC_START_BIT]  = sc_start;
    sc_val[SC_CLKSEL_BIT] = sc_clk;
    rd_data               = ff01rd ? sb : sc_val;
  end

  assign d = (ff01rd || ff02rd) ? rd_data : 'z;

  always_ff @(posedge clk) begin
    if (reset) begin
      sb         <= '0;
      sc_start   <= 1'b0;
      sc_clk     <= CLK_EXT;
      cnt        <= '0;
      sclk_out   <= 1'b1;
      ser_out    <= 1'b1;
      int_serial <= 1'b0;
    end else begin
      int_serial <= 1'b0;

      if (fall)
        ser_out <= sb[SER_BITS-1];

      if (int_mode && (rise || fall))
        sclk_out <= ~sclk_out;

      // Register writes take priority over a coincident shift edge.
      if (ff01wr)
        sb <= d;
      else if (rise && !ff02wr)
        sb <= {sb[SER_BITS-2:0], sin};

      if (ff02wr) begin
        sc_start <= d[SC_START_BIT];
        sc_clk   <= clk_sel_e'(d[SC_CLKSEL_BIT]);
        cnt      <= '0;
        sclk_out <= 1'b1;
      end else if (rise && !ff01wr) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          sc_start   <= 1'b0;
          int_serial <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_link.sv
// Directed self-checking bench for serial_link.
module tb_serial_link;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ff01wr = 1'b0, ff01rd = 1'b0, ff02wr = 1'b0, ff02rd = 1'b0;
  logic       tick_8192 = 1'b0;
  logic       sclk_in = 1'b1;
  logic       sin = 1'b0;
  logic       ser_out, sclk_out, sclk_oe, int_serial;
  logic [7:0] d_drv = 8'h00;
  logic       d_en = 1'b0;
  tri   [7:0] d;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  int_cnt = 8'h00;
  logic [7:0]  int_base;

  assign d = d_en ? d_drv : 'z;

  always #5 clk = ~clk;

  always @(negedge clk) if (int_serial) int_cnt <= int_cnt + 8'd1;

  serial_link #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .d         (d),
    .ff01wr    (ff01wr),
    .ff01rd    (ff01rd),
    .ff02wr    (ff02wr),
    .ff02rd    (ff02rd),
    .tick_8192 (tick_8192),
    .sclk_in   (sclk_in),
    .sin       (sin),
    .ser_out   (ser_out),
    .sclk_out  (sclk_out),
    .sclk_oe   (sclk_oe),
    .int_serial(int_serial)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic sel02, input logic [7:0] val);
    @(negedge clk);
    d_drv = val; d_en = 1'b1;
    if (sel02) ff02wr = 1'b1; else ff01wr = 1'b1;
    @(negedge clk);
    ff01wr = 1'b0; ff02wr = 1'b0; d_en = 1'b0;
  endtask

  task automatic rd_chk(input logic sel02, input string tag, input logic [7:0] exp);
    @(negedge clk);
    if (sel02) ff02rd = 1'b1; else ff01rd = 1'b1;
    #1;
    chk(tag, d, exp);
    ff01rd = 1'b0; ff02rd = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    tick_8192 = 1'b1;
    @(negedge clk);
    tick_8192 = 1'b0;
  endtask

  initial begin
    logic [7:0] pat_a5;
    logic [7:0] pat_3c;
    logic [7:0] pat_c3;
    pat_a5 = 8'hA5;
    pat_3c = 8'h3C;
    pat_c3 = 8'hC3;

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    rd_chk(1'b0, "rst_sb", 8'h00);
    rd_chk(1'b1, "rst_sc", 8'h7E);
    chk("rst_ser_out", {7'd0, ser_out}, 8'd1);
    chk("rst_sclk_out", {7'd0, sclk_out}, 8'd1);
    chk("rst_sclk_oe", {7'd0, sclk_oe}, 8'd0);
    chk("rst_int", {7'd0, int_serial}, 8'd0);

    // Internal clock transfer, SB=A5, sin=1
    sin = 1'b1;
    wr(1'b0, 8'hA5);
    wr(1'b1, 8'h81);
    chk("int_sclk_oe", {7'd0, sclk_oe}, 8'd1);
    int_base = int_cnt;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("int_ser_out_%0d", i), {7'd0, ser_out}, {7'd0, pat_a5[7-i]});
      chk($sformatf("int_sclk_low_%0d", i), {7'd0, sclk_out}, 8'd0);
      tick();
      chk($sformatf("int_irq_%0d", i), {7'd0, int_serial}, (i == 7) ? 8'd1 : 8'd0);
    end
    @(negedge clk);
    chk("int_irq_count", int_cnt - int_base, 8'd1);
    chk("int_sclk_idle", {7'd0, sclk_out}, 8'd1);
    rd_chk(1'b0, "int_sb", 8'hFF);
    rd_chk(1'b1, "int_sc", 8'h7F);

    // External clock transfer, SB=3C, sin pattern C3
    wr(1'b1, 8'h80);
    wr(1'b0, 8'h3C);
    chk("ext_sclk_oe", {7'd0, sclk_oe}, 8'd0);
    int_base = int_cnt;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sclk_in = 1'b0;
      sin = pat_c3[7-i];
      repeat (4) @(negedge clk);
      chk($sformatf("ext_ser_out_%0d", i), {7'd0, ser_out}, {7'd0, pat_3c[7-i]});
      sclk_in = 1'b1;
      if (i < 7) begin
        repeat (4) @(negedge clk);
      end else begin
        repeat (2) @(negedge clk);
        chk("ext_irq_early", {7'd0, int_serial}, 8'd0);
        @(negedge clk);
        chk("ext_irq_at3", {7'd0, int_serial}, 8'd1);
        @(negedge clk);
        chk("ext_irq_after", {7'd0, int_serial}, 8'd0);
      end
    end
    chk("ext_irq_count", int_cnt - int_base, 8'd1);
    rd_chk(1'b0, "ext_sb", 8'hC3);
    rd_chk(1'b1, "ext_sc", 8'h7E);

    // Abort after 3 rises, sin=0: A5 << 3 = 28
    sin = 1'b0;
    wr(1'b0, 8'hA5);
    wr(1'b1, 8'h81);
    int_base = int_cnt;
    repeat (6) tick();
    wr(1'b1, 8'h01);
    repeat (4) tick();
    chk("abort_irq_count", int_cnt - int_base, 8'd0);
    chk("abort_sclk_out", {7'd0, sclk_out}, 8'd1);
    rd_chk(1'b0, "abort_sb", 8'h28);
    rd_chk(1'b1, "abort_sc", 8'h7F);

    // Restart after abort: cnt must begin at 0, so interrupt only on the 16th tick
    sin = 1'b1;
    wr(1'b1, 8'h81);
    int_base = int_cnt;
    repeat (15) tick();
    chk("restart_no_early_irq", int_cnt - int_base, 8'd0);
    tick();
    chk("restart_irq", {7'd0, int_serial}, 8'd1);
    rd_chk(1'b0, "restart_sb", 8'hFF);

    // FF01 write coinciding with the 2nd rise: 80 then 7 counted shifts of 1 -> 7F
    wr(1'b0, 8'h00);
    wr(1'b1, 8'h81);
    int_base = int_cnt;
    repeat (3) tick();
    @(negedge clk);
    tick_8192 = 1'b1; ff01wr = 1'b1; d_drv = 8'h80; d_en = 1'b1;
    @(negedge clk);
    tick_8192 = 1'b0; ff01wr = 1'b0; d_en = 1'b0;
    rd_chk(1'b0, "coll_sb", 8'h80);
    repeat (13) tick();
    chk("coll_no_early_irq", int_cnt - int_base, 8'd0);
    tick();
    chk("coll_irq", {7'd0, int_serial}, 8'd1);
    rd_chk(1'b0, "coll_sb_final", 8'h7F);

    // Reset mid-transfer: after 3 ticks sclk_out=0 and ser_out=0
    sin = 1'b0;
    wr(1'b0, 8'hA5);
    wr(1'b1, 8'h81);
    repeat (3) tick();
    chk("mid_sclk_low", {7'd0, sclk_out}, 8'd0);
    chk("mid_ser_low", {7'd0, ser_out}, 8'd0);
    int_base = int_cnt;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_ser_out", {7'd0, ser_out}, 8'd1);
    chk("mrst_sclk_out", {7'd0, sclk_out}, 8'd1);
    chk("mrst_sclk_oe", {7'd0, sclk_oe}, 8'd0);
    rd_chk(1'b0, "mrst_sb", 8'h00);
    rd_chk(1'b1, "mrst_sc", 8'h7E);
    repeat (16) tick();
    chk("mrst_irq_count", int_cnt - int_base, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
